spine_port_arbiter: RTL and testbench
=====================================

Name: spine_port_arbiter

Overview:
Credit-based, packet-locking round-robin arbiter that shares one router output port among five flit sources. The sources are the GPU/NI injection path (index 0) and spine inputs 1-4 (indices 1-4). It sits between the per-input FIFOs of the enhanced router and a single egress link. The link replaces the "always ready" tie-off with downstream credit flow control. Flits are 16 bits; dest addr is carried in bits [15:10] and passes through untouched.

Parameters:
DWIDTH, 16, flit width
NUM_REQ, 5, number of requesters (0 = GPU/NI, 1..4 = spines)
CREDITS, 4, downstream buffer depth; initial and maximum credit count
CW, 3, credit counter width; must satisfy 2^CW > CREDITS

Ports:
ACLK  in  1  clock, rising edge
ARESETn  in  1  asynchronous active-low reset
arb_enable  in  1  permits new grants when 1
req_data  in  NUM_REQ*DWIDTH  flit from requester i at [i*DWIDTH +: DWIDTH]
req_valid  in  NUM_REQ  requester i presents a flit
req_last  in  NUM_REQ  presented flit is the last of its packet
req_ready  out  NUM_REQ  flit from requester i accepted this cycle when valid&ready
out_data  out  DWIDTH  registered egress flit
out_valid  out  1  one-cycle pulse per egress flit
out_last  out  1  egress flit is packet tail
out_src  out  3  index of requester that sourced out_data
credit_return  in  1  downstream freed one slot (pulse, one credit per cycle)
credit_count  out  CW  credits currently available
grant_vec  out  NUM_REQ  one-hot current owner, 0 when IDLE
busy  out  1  1 in LOCKED state
credit_err  out  1  sticky: credit_return received while count == CREDITS

Behaviour:
- Reset (async, ARESETn=0): state=IDLE; grant_vec=0, req_ready=0, out_valid=0, out_last=0, out_data=0, out_src=0, busy=0, credit_err=0, credit_count=CREDITS. Rotation pointer=NUM_REQ-1, so index 0 has highest priority first. Reset mid-packet discards the packet; no partial flits are emitted afterwards.
- FSM IDLE:
  - if arb_enable and any req_valid, select the first valid index searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - Next cycle: state=LOCKED, grant_vec=one-hot(winner), busy=1.
  - No flit is accepted in the arbitration cycle.
- FSM LOCKED, owner g:
  - req_ready[g] = (credit_count != 0), combinational from registered state and count; all other req_ready bits are 0.
  - Transfer = req_valid[g] & req_ready[g]. Next cycle: out_data=flit, out_last=req_last[g], out_src=g, out_valid=1. Otherwise out_valid=0.
  - Transfer with req_last[g]=1: next state=IDLE, ptr=g, grant_vec=0.
  - Invalid cycles inside a packet hold the lock; there is no timeout.
- arb_enable=0 blocks IDLE->LOCKED only. A packet in progress completes normally.
- Latency: request first seen in IDLE at cycle N -> grant at N+1 -> first transfer at N+1 -> out_valid at N+2. Single-flit packets from back-to-back winners give at most one flit per 2 cycles. Multi-flit packets stream at 1 flit/cycle while credits last.
- Credits: next = count - transfer + credit_return.
  - Simultaneous transfer and return leaves the count unchanged.
  - Return at count==CREDITS (no transfer that cycle): count saturates, credit_err set (cleared only by reset).
  - The count never underflows because ready is gated by count != 0.
- out_* are driven only from registers; no combinational path from req_* to out_*.
- Data is not modified; dest addr bits [15:10] pass through.

Test Plan:
- Reset with all req_valid=0 -> credit_count=4, grant_vec=0, out_valid=0, credit_err=0; holds while idle.
- Req 2 sends 3-flit packet 0xA001, 0xA002, 0xA003 (last on 3rd), credit_return=0 -> grant_vec=5'b00100 on cycle 1; out_valid on cycles 2-4 with out_src=2 and out_last only on 0xA003; credit_count 4->1; returns to IDLE.
- Req 0 and req 3 raise single-flit packets together after reset, both held valid -> order 0, 3, 0, 3. Each grant is separated by one IDLE cycle.
- Req 1 sends a 6-flit packet with no credit_return -> 4 flits emitted, then req_ready[1]=0 and the stall holds. A credit_return pulse releases exactly one flit per pulse; lock is retained through the stall.
- credit_count=2 with a transfer and credit_return in the same cycle -> count stays 2. credit_return at count=4 with no transfer -> count stays 4, credit_err=1 until ARESETn low.
- arb_enable dropped mid-packet on req 4 -> packet completes through last; no new grant while req 0 is valid. Re-enable -> req 0 is granted next cycle. ARESETn pulse mid-packet -> outputs reset immediately and nothing further is emitted.

Source files
------------

// File: rtl/spine_port_arbiter_if.sv
// Bundle of requester-side flit handshakes, egress flit bus and credit return for the
// spine port arbiter. The master side drives flits and credits; the slave side arbitrates.
interface spine_port_arbiter_if #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned CW      = 3
);
    logic [NUM_REQ*DWIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DWIDTH-1:0]         out_data;
    logic                      out_valid;
    logic                      out_last;
    logic [2:0]                out_src;
    logic                      credit_return;
    logic [CW-1:0]             credit_count;

    modport master (
        output req_data, req_valid, req_last, credit_return,
        input  req_ready, out_data, out_valid, out_last, out_src, credit_count
    );

    modport slave (
        input  req_data, req_valid, req_last, credit_return,
        output req_ready, out_data, out_valid, out_last, out_src, credit_count
    );
endinterface

// File: rtl/spine_port_arbiter.sv
// Credit-gated, packet-locking round-robin arbiter sharing one egress link among the
// GPU/NI injection path (index 0) and four spine inputs. Egress signals are all registered.
module spine_port_arbiter #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CW      = 3
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  arb_enable,
    spine_port_arbiter_if.slave   bus,
    output logic [NUM_REQ-1:0]    grant_vec,
    output logic                  busy,
    output logic                  credit_err
);
    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    localparam logic [CW-1:0] CreditMax = CW'(CREDITS);

    state_e            state_q, state_d;
    logic [2:0]        owner_q, owner_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        winner;
    logic              found;
    logic [CW-1:0]     credit_q, credit_d;
    logic              credit_err_q, credit_err_d;
    logic [DWIDTH-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [2:0]        out_src_q;
    logic              can_send;
    logic              xfer;
    logic              owner_last;
    logic [DWIDTH-1:0] owner_data;

    // Round-robin search starting just after the last packet owner.
    always_comb begin
        int unsigned idx;
        logic [2:0]  idx3;
        found  = 1'b0;
        winner = ptr_q;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx  = (32'(ptr_q) + i) % NUM_REQ;
            idx3 = 3'(idx);
            if (!found && bus.req_valid[idx3]) begin
                found  = 1'b1;
                winner = idx3;
            end
        end
    end

    assign can_send   = (state_q == StLocked) && (credit_q != '0);
    assign xfer       = can_send && bus.req_valid[owner_q];
    assign owner_last = bus.req_last[owner_q];
    assign owner_data = bus.req_data[32'(owner_q)*DWIDTH +: DWIDTH];

    assign bus.req_ready = can_send ? (NUM_REQ'(1) << owner_q) : '0;
    assign grant_vec     = (state_q == StLocked) ? (NUM_REQ'(1) << owner_q) : '0;
    assign busy          = (state_q == StLocked);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (arb_enable && found) begin
                    state_d = StLocked;
                    owner_d = winner;
                end
            end
            StLocked: begin
                // The lock is held across invalid cycles until the tail flit leaves.
                if (xfer && owner_last) begin
                    state_d = StIdle;
                    ptr_d   = owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        case ({xfer, bus.credit_return})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CreditMax) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d = credit_q + 1'b1;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            ptr_q        <= 3'(NUM_REQ - 1);
            credit_q     <= CreditMax;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= xfer;
            out_last_q  <= xfer && owner_last;
            if (xfer) begin
                out_data_q <= owner_data;
                out_src_q  <= owner_q;
            end
        end
    end

    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_src      = out_src_q;
    assign bus.credit_count = credit_q;
    assign credit_err       = credit_err_q;
endmodule

// File: tb/tb_spine_port_arbiter.sv
// Directed bench for spine_port_arbiter: per-requester source queues feed the DUT and a
// negedge monitor checks every egress flit against a queue of hand-ordered expectations.
module tb_spine_port_arbiter;
    localparam int unsigned DWIDTH  = 16;
    localparam int unsigned NUM_REQ = 5;
    localparam int unsigned CREDITS = 4;
    localparam int unsigned CW      = 3;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [2:0]  src;
    } flit_t;

    logic               ACLK;
    logic               ARESETn;
    logic               arb_enable;
    logic [NUM_REQ-1:0] grant_vec;
    logic               busy;
    logic               credit_err;

    spine_port_arbiter_if #(.DWIDTH(DWIDTH), .NUM_REQ(NUM_REQ), .CW(CW)) bus ();

    spine_port_arbiter #(
        .DWIDTH(DWIDTH), .NUM_REQ(NUM_REQ), .CREDITS(CREDITS), .CW(CW)
    ) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .arb_enable(arb_enable),
        .bus(bus),
        .grant_vec(grant_vec),
        .busy(busy),
        .credit_err(credit_err)
    );

    int          total;
    int          bad;
    int          cyc;
    int          g_cyc;
    flit_t       exp_q[$];
    int          out_cyc[$];
    logic [16:0] src_q[NUM_REQ][$];
    logic [NUM_REQ-1:0] acc;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push_pkt(input int src, input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            flit_t f;
            f.data = base + 16'(k);
            f.last = (k == n - 1);
            f.src  = 3'(src);
            src_q[src].push_back({f.last, f.data});
            exp_q.push_back(f);
        end
    endtask

    task automatic wait_exp(input string name, input int left, input int budget);
        int n = 0;
        while (exp_q.size() > left && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'(left));
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 20) begin
            tick();
            n++;
        end
        chk(name, {31'd0, busy}, 32'd1);
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        exp_q.delete();
        tick();
        tick();
        ARESETn = 1'b1;
        tick();
        out_cyc.delete();
    endtask

    // Upstream FIFO model: pop on accepted flit, keep presenting the queue head.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        acc           = '0;
        forever begin
            @(negedge ACLK);
            acc = bus.req_valid & bus.req_ready;
            @(posedge ACLK);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    bus.req_valid[i]               = 1'b1;
                    bus.req_last[i]                = src_q[i][0][16];
                    bus.req_data[i*DWIDTH +: DWIDTH] = src_q[i][0][15:0];
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_last[i]  = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESETn && bus.out_valid) begin
                out_cyc.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_flit: got data=%0h src=%0d expected none",
                             bus.out_data, bus.out_src);
                end else begin
                    flit_t e;
                    e = exp_q.pop_front();
                    if (bus.out_data !== e.data || bus.out_last !== e.last ||
                        bus.out_src !== e.src) begin
                        bad++;
                        $display("FAIL flit: got data=%0h last=%0b src=%0d expected data=%0h last=%0b src=%0d",
                                 bus.out_data, bus.out_last, bus.out_src, e.data, e.last, e.src);
                    end
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        ARESETn       = 1'b0;
        arb_enable    = 1'b1;
        bus.credit_return = 1'b0;
        tick();
        tick();
        ARESETn = 1'b1;
        tick();

        // Reset state, held while idle
        chk("rst_credit", 32'(bus.credit_count), 32'd4);
        chk("rst_grant", 32'(grant_vec), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_err", 32'(credit_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("idle_credit", 32'(bus.credit_count), 32'd4);
        chk("idle_grant", 32'(grant_vec), 32'd0);

        // 3-flit packet from req 2
        out_cyc.delete();
        push_pkt(2, 3, 16'hA001);
        wait_busy("t2_busy");
        g_cyc = cyc;
        chk("t2_grant", 32'(grant_vec), 32'b00100);
        wait_exp("t2_drain", 0, 20);
        tick();
        chk("t2_nflits", 32'(out_cyc.size()), 32'd3);
        if (out_cyc.size() == 3) begin
            chk("t2_latency", 32'(out_cyc[0] - g_cyc), 32'd1);
            chk("t2_stream", 32'(out_cyc[2] - out_cyc[0]), 32'd2);
        end
        chk("t2_credit", 32'(bus.credit_count), 32'd1);
        chk("t2_idle", 32'(grant_vec), 32'd0);

        // Req 0 and 3 alternate single-flit packets
        do_reset();
        push_pkt(0, 1, 16'h0101);
        push_pkt(3, 1, 16'h3301);
        push_pkt(0, 1, 16'h0102);
        push_pkt(3, 1, 16'h3302);
        wait_exp("t3_drain", 0, 40);
        chk("t3_nflits", 32'(out_cyc.size()), 32'd4);
        if (out_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                chk("t3_gap", 32'(out_cyc[i] - out_cyc[i-1]), 32'd2);
            end
        end

        // 6-flit packet from req 1 stalls on credits
        do_reset();
        push_pkt(1, 6, 16'hB001);
        wait_exp("t4_first4", 2, 30);
        repeat (4) tick();
        chk("t4_stall_left", 32'(exp_q.size()), 32'd2);
        chk("t4_credit0", 32'(bus.credit_count), 32'd0);
        chk("t4_ready0", 32'(bus.req_ready), 32'd0);
        chk("t4_locked", 32'(grant_vec), 32'b00010);
        bus.credit_return = 1'b1;
        tick();
        bus.credit_return = 1'b0;
        repeat (4) tick();
        chk("t4_one_release", 32'(exp_q.size()), 32'd1);
        chk("t4_still_locked", 32'(grant_vec), 32'b00010);
        bus.credit_return = 1'b1;
        tick();
        bus.credit_return = 1'b0;
        wait_exp("t4_drain", 0, 20);
        tick();
        chk("t4_idle", 32'(grant_vec), 32'd0);
        chk("t4_credit_end", 32'(bus.credit_count), 32'd0);

        // Simultaneous transfer and return, then overflow return
        bus.credit_return = 1'b1;
        tick();
        tick();
        bus.credit_return = 1'b0;
        tick();
        chk("t5_credit2", 32'(bus.credit_count), 32'd2);
        push_pkt(2, 1, 16'h8C01);
        begin
            int n = 0;
            while (!bus.req_ready[2] && n < 20) begin
                tick();
                n++;
            end
        end
        chk("t5_ready", 32'(bus.req_ready), 32'b00100);
        bus.credit_return = 1'b1;
        tick();
        bus.credit_return = 1'b0;
        chk("t5_xfer_ret", 32'(bus.credit_count), 32'd2);
        wait_exp("t5_drain", 0, 10);
        bus.credit_return = 1'b1;
        tick();
        tick();
        bus.credit_return = 1'b0;
        tick();
        chk("t5_credit4", 32'(bus.credit_count), 32'd4);
        chk("t5_no_err", 32'(credit_err), 32'd0);
        bus.credit_return = 1'b1;
        tick();
        bus.credit_return = 1'b0;
        tick();
        chk("t5_saturate", 32'(bus.credit_count), 32'd4);
        chk("t5_err", 32'(credit_err), 32'd1);
        repeat (3) tick();
        chk("t5_err_sticky", 32'(credit_err), 32'd1);
        do_reset();
        chk("t5_err_clr", 32'(credit_err), 32'd0);

        // arb_enable dropped mid-packet
        push_pkt(4, 3, 16'hD401);
        wait_busy("t6_busy");
        chk("t6_grant4", 32'(grant_vec), 32'b10000);
        arb_enable = 1'b0;
        push_pkt(0, 1, 16'h0A01);
        wait_exp("t6_pkt_done", 1, 20);
        repeat (3) tick();
        chk("t6_no_grant", 32'(grant_vec), 32'd0);
        chk("t6_held", 32'(exp_q.size()), 32'd1);
        arb_enable = 1'b1;
        tick();
        chk("t6_regrant", 32'(grant_vec), 32'b00001);
        wait_exp("t6_drain", 0, 10);

        // Reset in the middle of a packet
        do_reset();
        push_pkt(1, 4, 16'hE101);
        wait_exp("t7_two_out", 2, 20);
        ARESETn = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        exp_q.delete();
        #1;
        chk("t7_valid", 32'(bus.out_valid), 32'd0);
        chk("t7_data", 32'(bus.out_data), 32'd0);
        chk("t7_grant", 32'(grant_vec), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_credit", 32'(bus.credit_count), 32'd4);
        tick();
        tick();
        ARESETn = 1'b1;
        repeat (10) tick();
        chk("t7_nothing_more", 32'(out_cyc.size()), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
